// File: rtl/systolic_seq_pkg.sv
// Shared state encoding, default phase lengths and counter width for the
// 3x3-over-4x4 convolution sequencer.
package systolic_seq_pkg;

   localparam int unsigned SEQ_CNT_W     = 4;
   localparam int unsigned DEF_FEED0_LEN = 9;
   localparam int unsigned DEF_FEED1_LEN = 3;
   localparam int unsigned DEF_FLUSH_LEN = 6;
   localparam int unsigned DEF_SHIFT_LEN = 3;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FEED0  = 4'd1,
      S_FLUSH0 = 4'd2,
      S_SHIFT0 = 4'd3,
      S_CAPT0  = 4'd4,
      S_CLEAR  = 4'd5,
      S_FEED1  = 4'd6,
      S_FLUSH1 = 4'd7,
      S_SHIFT1 = 4'd8,
      S_CAPT1  = 4'd9,
      S_DONE   = 4'd10
   } seq_state_e;

   // Fixed phase order of one run; DONE falls back to IDLE.
   function automatic seq_state_e next_phase(input seq_state_e s);
      case (s)
         S_FEED0:  return S_FLUSH0;
         S_FLUSH0: return S_SHIFT0;
         S_SHIFT0: return S_CAPT0;
         S_CAPT0:  return S_CLEAR;
         S_CLEAR:  return S_FEED1;
         S_FEED1:  return S_FLUSH1;
         S_FLUSH1: return S_SHIFT1;
         S_SHIFT1: return S_CAPT1;
         S_CAPT1:  return S_DONE;
         default:  return S_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/systolic_sequencer_phase_counter.sv
// Phase counter shared by every timed state: counts 0..len-1 and flags the
// final cycle so the FSM can advance without ever wrapping.
module phase_counter
   import systolic_seq_pkg::*;
#(
   parameter int unsigned W = SEQ_CNT_W
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] len,
   output logic [W-1:0] cnt,
   output logic         last
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == len - W'(1));

endmodule

// File: rtl/systolic_sequencer.sv
// Control FSM sequencing one full convolution (diagonal pass, then o11 pass)
// on the 3x3 PE array, with start/busy/done handshake and abort.
module systolic_sequencer
   import systolic_seq_pkg::*;
#(
   parameter int unsigned CNT_W     = SEQ_CNT_W,
   parameter int unsigned FEED0_LEN = DEF_FEED0_LEN,
   parameter int unsigned FEED1_LEN = DEF_FEED1_LEN,
   parameter int unsigned FLUSH_LEN = DEF_FLUSH_LEN,
   parameter int unsigned SHIFT_LEN = DEF_SHIFT_LEN
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             feed_valid,
   output logic [CNT_W-1:0] feed_idx,
   output logic             pass_sel,
   output logic             mode,
   output logic             pe_clr,
   output logic             cap_diag,
   output logic             cap_sum
);

   seq_state_e       state_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] phaseLen;
   logic             cntLast;
   logic             active;

   assign active = (state_q != S_IDLE);

   // Single-cycle states use length 1 so the same counter drives every exit.
   always_comb begin
      phaseLen = CNT_W'(1);
      case (state_q)
         S_FEED0:            phaseLen = CNT_W'(FEED0_LEN);
         S_FEED1:            phaseLen = CNT_W'(FEED1_LEN);
         S_FLUSH0, S_FLUSH1: phaseLen = CNT_W'(FLUSH_LEN);
         S_SHIFT0, S_SHIFT1: phaseLen = CNT_W'(SHIFT_LEN);
         default:            phaseLen = CNT_W'(1);
      endcase
   end

   phase_counter #(.W(CNT_W)) u_cnt (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (!active || cntLast || abort),
      .en     (active),
      .len    (phaseLen),
      .cnt    (cnt),
      .last   (cntLast)
   );

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)
         state_q <= S_IDLE;
      else if (!active) begin
         if (start)
            state_q <= S_FEED0;
      end
      else if (abort)
         state_q <= S_IDLE;
      else if (cntLast)
         state_q <= next_phase(state_q);
   end

   // Moore decode; abort reaches only pe_clr so the array is scrubbed at once.
   always_comb begin
      busy       = active;
      done       = (state_q == S_DONE);
      feed_valid = (state_q == S_FEED0) || (state_q == S_FEED1);
      feed_idx   = feed_valid ? cnt : '0;
      pass_sel   = state_q inside {S_CLEAR, S_FEED1, S_FLUSH1, S_SHIFT1, S_CAPT1, S_DONE};
      mode       = (state_q == S_SHIFT0) || (state_q == S_SHIFT1);
      pe_clr     = (state_q == S_CLEAR) || (abort && active);
      cap_diag   = (state_q == S_CAPT0);
      cap_sum    = (state_q == S_CAPT1);
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench: a default and an overridden sequencer share start/abort;
// a run-position model predicts each cycle's outputs for both.
module tb_systolic_sequencer;

   typedef logic [11:0] vec_t;
   typedef struct {
      vec_t expD;
      vec_t expO;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;

   logic       busyD, doneD, fvD, passD, modeD, clrD, capDD, capSD;
   logic [3:0] idxD;
   logic       busyO, doneO, fvO, passO, modeO, clrO, capDO, capSO;
   logic [3:0] idxO;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   posD = 0;
   int   posO = 0;

   always #5 clk = ~clk;

   systolic_sequencer u_dflt (
      .clk_in(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busyD), .done(doneD), .feed_valid(fvD), .feed_idx(idxD),
      .pass_sel(passD), .mode(modeD), .pe_clr(clrD),
      .cap_diag(capDD), .cap_sum(capSD)
   );

   systolic_sequencer #(
      .FEED0_LEN(4), .FEED1_LEN(2), .FLUSH_LEN(1), .SHIFT_LEN(2)
   ) u_ovr (
      .clk_in(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busyO), .done(doneO), .feed_valid(fvO), .feed_idx(idxO),
      .pass_sel(passO), .mode(modeO), .pe_clr(clrO),
      .cap_diag(capDO), .cap_sum(capSO)
   );

   // Output vector: busy done feed_valid feed_idx[3:0] pass_sel mode pe_clr cap_diag cap_sum
   function automatic vec_t modelOut(input int pos, input bit ab,
                                     input int f0, input int f1, input int fl, input int sh);
      int   capt0, clrPos, capt1, total, idx;
      logic fv, md;
      if (pos == 0)
         return '0;
      capt0  = f0 + fl + sh + 1;
      clrPos = capt0 + 1;
      capt1  = clrPos + f1 + fl + sh + 1;
      total  = capt1 + 1;
      fv     = (pos <= f0) || (pos > clrPos && pos <= clrPos + f1);
      idx    = (pos <= f0) ? pos - 1 : (fv ? pos - clrPos - 1 : 0);
      md     = (pos > f0 + fl && pos < capt0) || (pos > clrPos + f1 + fl && pos < capt1);
      return {1'b1, pos == total, fv, 4'(idx), pos >= clrPos, md,
              (pos == clrPos) || ab, pos == capt0, pos == capt1};
   endfunction

   function automatic int runLen(input int f0, input int f1, input int fl, input int sh);
      return f0 + fl + sh + 2 + f1 + fl + sh + 2;
   endfunction

   function automatic int modelNext(input int pos, input bit s, input bit ab, input int total);
      if (pos == 0)
         return s ? 1 : 0;
      if (ab || pos == total)
         return 0;
      return pos + 1;
   endfunction

   // One cycle: drive inputs just after the edge, predict, then advance the models.
   task automatic applyStimulus(input bit s, input bit a, input bit r);
      exp_t e;
      @(posedge clk);
      #1;
      start = s;
      abort = a;
      rst   = r;
      if (!r) begin
         posD = 0;
         posO = 0;
      end
      e.expD = modelOut(posD, a, 9, 3, 6, 3);
      e.expO = modelOut(posO, a, 4, 2, 1, 2);
      sb.push_back(e);
      if (r) begin
         posD = modelNext(posD, s, a, runLen(9, 3, 6, 3));
         posO = modelNext(posO, s, a, runLen(4, 2, 1, 2));
      end
   endtask

   task automatic checkOutput(input string name, input vec_t got, input vec_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
      end
   endtask

   // Monitor: one prediction per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("dflt", {busyD, doneD, fvD, idxD, passD, modeD, clrD, capDD, capSD}, e.expD);
            checkOutput("ovr",  {busyO, doneO, fvO, idxO, passO, modeO, clrO, capDO, capSO}, e.expO);
         end
      end
   end

   initial begin
      // Reset state, then release.
      repeat (3) applyStimulus(0, 0, 0);
      repeat (2) applyStimulus(0, 0, 1);

      // Reset asserted in cycle 12 of a run.
      applyStimulus(1, 0, 1);
      for (int c = 1; c <= 11; c++) applyStimulus(0, 0, 1);
      repeat (2) applyStimulus(0, 0, 0);
      repeat (3) applyStimulus(0, 0, 1);

      // Single run with ignored start pulses at c5 and c34.
      applyStimulus(1, 0, 1);
      for (int c = 1; c <= 36; c++) applyStimulus(c == 5 || c == 34, 0, 1);
      repeat (20) applyStimulus(0, 0, 1);

      // Start held high: back-to-back runs.
      repeat (80) applyStimulus(1, 0, 1);
      repeat (40) applyStimulus(0, 0, 1);

      // Abort in FEED1 (c22), then a clean run.
      applyStimulus(1, 0, 1);
      for (int c = 1; c <= 21; c++) applyStimulus(0, 0, 1);
      applyStimulus(0, 1, 1);
      repeat (4) applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 1);
      repeat (40) applyStimulus(0, 0, 1);

      // Abort in CAPT0 (c19).
      applyStimulus(1, 0, 1);
      for (int c = 1; c <= 18; c++) applyStimulus(0, 0, 1);
      applyStimulus(0, 1, 1);
      repeat (4) applyStimulus(0, 0, 1);

      // Abort with start while idle still starts a run.
      repeat (20) applyStimulus(0, 0, 1);
      applyStimulus(1, 1, 1);
      repeat (40) applyStimulus(0, 0, 1);

      // Randomized start/abort/reset traffic.
      for (int c = 0; c < 2000; c++)
         applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                       $urandom_range(0, 299) != 0);
      repeat (40) applyStimulus(0, 0, 1);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain got=%0d exp=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
- Control FSM that sequences one full 3x3-filter-over-4x4-input convolution on the 3x3 PE array, replacing the free-running 8-bit counter and its ad-hoc decodes.
- Drives the following signals:
  - operand-select index for the feed muxes
  - pass select (pass 0 = o00/o01/o10 diagonal, pass 1 = o11 rows)
  - PE mode
  - PE clear
  - output-capture strobes
- Start/busy/done handshake toward the top-level host, plus an abort input.

Parameters:
- FEED0_LEN, 9, operand cycles fed in pass 0 (feed_idx 0..FEED0_LEN-1)
- FEED1_LEN, 3, operand cycles fed in pass 1
- FLUSH_LEN, 6, zero-feed cycles after each feed phase, letting partial sums propagate
- SHIFT_LEN, 3, cycles with mode=1 after each flush, shifting results out of the array
- CNT_W, 4, phase counter width; every *_LEN must lie in 1..2^CNT_W-1

Ports:
- clk_in  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  cancel the current run; sampled in every non-IDLE state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes; not asserted on abort
- feed_valid  out  1  high during FEED0/FEED1; when low, array operand inputs are zero
- feed_idx  out  CNT_W  operand index within the current feed phase; 0 when feed_valid=0
- pass_sel  out  1  0 in pass 0 states, 1 from CLEAR through DONE
- mode  out  1  PE mode; high only in SHIFT0/SHIFT1
- pe_clr  out  1  synchronous clear to all PEs; high in CLEAR and in the abort cycle
- cap_diag  out  1  load strobe for o00/o01/o10 holding registers
- cap_sum  out  1  load strobe for the o11 adder-result register

Behaviour:
- States: IDLE, FEED0, FLUSH0, SHIFT0, CAPT0, CLEAR, FEED1, FLUSH1, SHIFT1, CAPT1, DONE. One phase counter cnt[CNT_W-1:0].
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, all outputs 0.
- Outputs are a Moore decode of the registered state and cnt; no combinational path from start/abort to any output, except pe_clr on abort (see below).
- IDLE: start=1 at an edge → FEED0, cnt=0.
- Timed phases: a phase of length L holds L cycles, cnt running 0..L-1; at cnt=L-1 go to the next state with cnt=0.
  - FEED0 (FEED0_LEN) → FLUSH0 (FLUSH_LEN) → SHIFT0 (SHIFT_LEN) → CAPT0 (1) → CLEAR (1)
  - → FEED1 (FEED1_LEN) → FLUSH1 → SHIFT1 → CAPT1 (1) → DONE (1) → IDLE.
- feed_idx = cnt in FEED0/FEED1; 0 otherwise.
- Strobes: cap_diag=1 only in CAPT0; cap_sum=1 only in CAPT1; done=1 only in DONE.
- Default timing: cycle 1 = first cycle after the start edge.
  - FEED0 c1-9, FLUSH0 c10-15, SHIFT0 c16-18, CAPT0 c19, CLEAR c20
  - FEED1 c21-23, FLUSH1 c24-29, SHIFT1 c30-32, CAPT1 c33, DONE c34, IDLE c35
  - busy high c1-c34.
- start while busy (including DONE): ignored, not queued. Back-to-back runs: start held high → next run's FEED0 begins in c36.
- abort=1 in any non-IDLE state:
  - pe_clr=1 in that same cycle (combinational OR, the only input-to-output path)
  - next state IDLE, cnt=0; no done, no capture strobe.
- abort in the CAPT0/CAPT1 cycle: strobes still assert that cycle (Moore); pe_clr also 1.
- abort in IDLE: no effect; start with abort in IDLE still starts.
- Counter never wraps: the phase length check precedes increment. cnt width is sufficient by the parameter constraint.

Decomposition:
- Package systolic_seq_pkg:
  - state encoding constants (4-bit)
  - default lengths 9/3/6/3
  - CNT_W
- One sub-module, phase_counter:
  - inputs: clr, en, len
  - outputs: cnt, last (cnt==len-1)
  - reused for every timed state.
- FSM next-state and output decode stay in systolic_sequencer.

Test Plan:
- Reset mid-run: assert rst=0 at c12 → all outputs 0 immediately; after release, state IDLE, busy=0.
- Single run, defaults: start pulse → check each window:
  - feed_valid c1-9 with feed_idx 0..8
  - mode c16-18, cap_diag c19, pe_clr c20, pass_sel=1 c20-34
  - feed_idx 0..2 c21-23, mode c30-32, cap_sum c33, done c34 only, busy c1-34.
- start held high continuously: runs separated by exactly one IDLE cycle; done every 35 cycles. start re-pulsed at c5 and c34 has no effect.
- abort at c22 (FEED1): pe_clr=1 c22; busy=0 and state IDLE at c23; no done or cap_sum ever. A subsequent start gives a clean full run.
- abort at c19 (CAPT0): cap_diag=1 and pe_clr=1 in c19; IDLE at c20.
- Parameter override FEED0_LEN=4, FLUSH_LEN=1, SHIFT_LEN=2, FEED1_LEN=2:
  - feed_idx 0..3 c1-4, mode c6-7, cap_diag c8, pe_clr c9
  - cap_sum c15, done c16.
